// File: rtl/alu_issue_stage.sv
// Issue stage for the 16-bit registered ALU: 8x16 register file, operand
// bypass from write-back, one-cycle load-use stall, host load port, retire count.
module alu_issue_stage #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [2:0]       instr_rd,
    input  logic [2:0]       instr_ra,
    input  logic [2:0]       instr_rb,
    input  logic             ld_valid,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [15:0]      retire_count,
    output logic             busy
);

    logic [NREGS-1:0][WIDTH-1:0] rf;

    logic       e_valid;
    logic [2:0] e_rd;
    logic       w_valid;
    logic [2:0] w_rd;

    logic             hazard;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    // Result of E is not registered by the ALU yet, so it cannot be bypassed
    assign hazard = e_valid && (e_rd == instr_ra || e_rd == instr_rb);

    assign instr_ready = !ld_valid && !hazard;
    assign accept      = instr_valid && instr_ready;

    assign opa = (w_valid && w_rd == instr_ra) ? alu_result : rf[instr_ra];
    assign opb = (w_valid && w_rd == instr_rb) ? alu_result : rf[instr_rb];

    assign wb_valid = w_valid;
    assign wb_rd    = w_rd;
    assign wb_data  = alu_result;
    assign busy     = e_valid || w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= 3'b111;
            e_valid <= 1'b0;
            e_rd    <= '0;
            w_valid <= 1'b0;
            w_rd    <= '0;
        end else begin
            e_valid <= accept;
            w_valid <= e_valid;
            w_rd    <= e_rd;
            if (accept) begin
                alu_a  <= opa;
                alu_b  <= opb;
                alu_op <= instr_op;
                e_rd   <= instr_rd;
            end
        end
    end

    // Write-back is applied last so it wins over a host load to the same entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '0;
        end else begin
            if (ld_valid)
                rf[ld_addr] <= ld_data;
            if (w_valid)
                rf[w_rd] <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_count <= '0;
        else if (w_valid)
            retire_count <= retire_count + 16'd1;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small registered ALU model
// standing in for the downstream 16-bit ALU.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_ra;
    logic [2:0]  instr_rb;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] retire_count;
    logic        busy;

    int n_checks;
    int n_fail;
    int exp_ret;

    alu_issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_ra     (instr_ra),
        .instr_rb     (instr_rb),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alu_result <= 16'h0000;
        else
            alu_result <= alu_f(alu_op, alu_a, alu_b);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
    endtask

    // Offers one instruction and returns just after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb);
        int st;
        instr_op    = op;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
        instr_valid = 1'b1;
        #1;
        st = 0;
        while (!instr_ready && st < 8) begin
            step();
            st++;
        end
        if (!instr_ready)
            check("issue_ready_timeout", {31'd0, instr_ready}, 32'd1);
        step();
        instr_valid = 1'b0;
        exp_ret++;
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] r,
                          input logic [15:0] exp);
        issue(3'b111, 3'd7, r, r);
        check(tag, {16'd0, alu_a}, {16'd0, exp});
    endtask

    task automatic drain();
        step();
        step();
        step();
    endtask

    logic [15:0] exp_s [4];

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_ret     = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_ra    = '0;
        instr_rb    = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        exp_s[0]    = 16'h0007;
        exp_s[1]    = 16'hFFFF;
        exp_s[2]    = 16'h0000;
        exp_s[3]    = 16'h0007;
        do_reset();

        check("rst_alu_op", {29'd0, alu_op}, 32'd7);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_retire", {16'd0, retire_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);

        // Single ADD r3 = r1 + r2
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        issue(3'b000, 3'd3, 3'd1, 3'd2);
        check("add_alu_a", {16'd0, alu_a}, 32'd3);
        check("add_alu_b", {16'd0, alu_b}, 32'd4);
        check("add_alu_op", {29'd0, alu_op}, 32'd0);
        check("add_busy", {31'd0, busy}, 32'd1);
        step();
        check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("add_wb_rd", {29'd0, wb_rd}, 32'd3);
        check("add_wb_data", {16'd0, wb_data}, 32'h7);
        step();
        check("add_retire", {16'd0, retire_count}, 32'd1);
        check("add_wb_done", {31'd0, wb_valid}, 32'd0);

        // Dependent XOR stalls one cycle, then takes r3 from bypass
        load(3'd3, 16'h0000);
        instr_op    = 3'b000;
        instr_rd    = 3'd3;
        instr_ra    = 3'd1;
        instr_rb    = 3'd2;
        instr_valid = 1'b1;
        #1;
        check("dep_ready0", {31'd0, instr_ready}, 32'd1);
        step();
        instr_op = 3'b101;
        instr_rd = 3'd4;
        instr_ra = 3'd3;
        instr_rb = 3'd1;
        #1;
        check("dep_stall", {31'd0, instr_ready}, 32'd0);
        step();
        check("dep_ready1", {31'd0, instr_ready}, 32'd1);
        step();
        instr_valid = 1'b0;
        exp_ret += 2;
        check("dep_bypass_a", {16'd0, alu_a}, 32'h7);
        check("dep_alu_b", {16'd0, alu_b}, 32'h3);
        drain();
        rd_reg("dep_r4", 3'd4, 16'h0004);
        rd_reg("dep_r3", 3'd3, 16'h0007);
        drain();
        check("dep_retire", {16'd0, retire_count}, exp_ret);

        // Four independent instructions, valid held high
        instr_ra = 3'd1;
        instr_rb = 3'd2;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                instr_op    = 3'(i);
                instr_rd    = 3'(3 + i);
                instr_valid = 1'b1;
                #1;
                check("str_ready", {31'd0, instr_ready}, 32'd1);
            end else begin
                instr_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 4) begin
                check("str_wb_valid", {31'd0, wb_valid}, 32'd1);
                check("str_wb_rd", {29'd0, wb_rd}, 32'(3 + i - 1));
                check("str_wb_data", {16'd0, wb_data}, {16'd0, exp_s[i-1]});
            end else begin
                check("str_wb_idle", {31'd0, wb_valid}, 32'd0);
            end
        end
        exp_ret += 4;
        drain();
        check("str_retire", {16'd0, retire_count}, exp_ret);

        // Host load blocks issue; write-back beats a load to the same reg
        instr_op    = 3'b000;
        instr_rd    = 3'd5;
        instr_ra    = 3'd1;
        instr_rb    = 3'd2;
        instr_valid = 1'b1;
        ld_valid    = 1'b1;
        ld_addr     = 3'd0;
        ld_data     = 16'h1234;
        #1;
        check("ld_blocks", {31'd0, instr_ready}, 32'd0);
        step();
        check("ld_no_issue", {31'd0, busy}, 32'd0);
        ld_valid = 1'b0;
        #1;
        check("ld_released", {31'd0, instr_ready}, 32'd1);
        step();
        instr_valid = 1'b0;
        exp_ret++;
        step();
        check("col_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("col_wb_rd", {29'd0, wb_rd}, 32'd5);
        load(3'd5, 16'hBEEF);
        rd_reg("col_r5", 3'd5, 16'h0007);
        rd_reg("ld_r0", 3'd0, 16'h1234);
        drain();
        check("col_retire", {16'd0, retire_count}, exp_ret);

        // Reset while both E and W hold instructions
        load(3'd1, 16'h0055);
        instr_op    = 3'b000;
        instr_rd    = 3'd2;
        instr_ra    = 3'd1;
        instr_rb    = 3'd1;
        instr_valid = 1'b1;
        step();
        instr_rd = 3'd3;
        step();
        instr_valid = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_wb_valid", {31'd0, wb_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("mid_rst_alu_op", {29'd0, alu_op}, 32'd7);
        check("mid_rst_retire", {16'd0, retire_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_wb", {31'd0, wb_valid}, 32'd0);
        check("post_rst_retire", {16'd0, retire_count}, 32'd0);
        rd_reg("post_rst_r1", 3'd1, 16'h0000);
        rd_reg("post_rst_r2", 3'd2, 16'h0000);

        // retire_count wraps after 65536 write-backs
        do_reset();
        instr_op    = 3'b000;
        instr_rd    = 3'd6;
        instr_ra    = 3'd1;
        instr_rb    = 3'd2;
        instr_valid = 1'b1;
        for (int i = 0; i < 65536; i++)
            step();
        instr_valid = 1'b0;
        step();
        check("wrap_ffff", {16'd0, retire_count}, 32'hFFFF);
        step();
        check("wrap_zero", {16'd0, retire_count}, 32'h0000);
        check("wrap_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue stage for the 16-bit registered ALU.
- Accepts register-addressed instructions on a valid/ready interface and reads operands from an internal 8x16 register file.
- Drives the ALU opcode and operand inputs, then writes the ALU's registered result back to the register file.
- Provides write-back bypass, a one-cycle load-use stall, a host load port and a retire counter.

Parameters:
- NREGS, 8, register-file depth; the design supports only 8 (3-bit register indices).
- WIDTH, 16, data width; must match the ALU operand width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid && ready
- instr_op  in  3  ALU opcode, passed through unchanged
- instr_rd  in  3  destination register
- instr_ra  in  3  source register for operand A
- instr_rb  in  3  source register for operand B
- ld_valid  in  1  host register-file write
- ld_addr  in  3  host write address
- ld_data  in  16  host write data
- alu_a  out  16  to ALU inputA
- alu_b  out  16  to ALU inputB
- alu_op  out  3  to ALU opcode
- alu_result  in  16  from ALU result (registered inside ALU, one cycle)
- wb_valid  out  1  write-back occurring this cycle
- wb_rd  out  3  write-back register
- wb_data  out  16  write-back data (equals alu_result)
- retire_count  out  16  number of instructions written back, wraps
- busy  out  1  high when E or W stage is occupied

Behaviour:
- Reset (asynchronous): all register-file entries, alu_a, alu_b, retire_count = 0; alu_op = 3'b111 (ALU default, output 0); E/W valid bits = 0.
- Pipeline:
  - Accept in cycle N loads alu_a, alu_b, alu_op and E-stage {valid, rd} at the edge ending N.
  - ALU sees the operands in N+1 and registers the result at the end of N+1.
  - In N+2 the W stage is valid: wb_valid=1, wb_data=alu_result, and the register-file write to wb_rd occurs at the end of N+2.
  - Latency from accept to register-file update: 3 edges. Throughput: 1 per cycle without hazards.
- Operand read at accept:
  - Priority 1: if W valid and W.rd == ra, bypass alu_result.
  - Priority 2: otherwise read the register file. Same rule applies to rb.
  - A ld write landing at the same edge is not visible to that read.
- Hazard: if E valid and E.rd matches instr_ra or instr_rb, instr_ready = 0 for one cycle. The next cycle that instruction is in W and bypass supplies the operand.
- instr_ready = !ld_valid && !hazard. ready may depend on the instruction fields; valid must not depend on ready.
- When no instruction is accepted, E valid clears at the edge. alu_a, alu_b and alu_op hold their values, so the ALU result is recomputed but not written back.
- Load port:
  - ld_valid writes ld_data to ld_addr at the edge and blocks acceptance that cycle.
  - If a write-back targets the same address at the same edge, write-back wins.
  - The host is responsible for waiting on busy=0 when load ordering matters.
- retire_count increments by 1 on each wb_valid cycle; 0xFFFF wraps to 0x0000.
- Reset mid-operation: in-flight E/W instructions are discarded with no write-back, and the register file clears.
- No arithmetic is done here; widths are 16 bits throughout.

Test Plan:
- Load r1=0x0003, r2=0x0004; issue ADD(000) r3=r1+r2 -> alu_a=3, alu_b=4 one cycle after accept; wb_valid with wb_rd=3, wb_data=0x0007 two cycles after accept; retire_count=1.
- Back-to-back dependent: ADD r3=r1+r2 then XOR(101) r4=r3,r1 -> instr_ready low exactly 1 cycle; XOR operand A bypassed = 0x0007; r4=0x0004.
- Independent stream of 4 instructions with valid held high -> instr_ready never drops; 4 consecutive wb_valid cycles; retire_count=4.
- ld_valid asserted with instr_valid, then a ld to r5 at the same edge as a write-back to r5 -> instr_ready=0 while ld_valid is high; r5 holds the write-back value afterwards.
- retire_count preset by running 65536 retires -> value wraps to 0x0000.
- rst_n asserted while E and W are occupied -> no write-back occurs, all outputs at reset values, register file reads 0.
